// File: rtl/if_stage_hazard_pkg.sv
// Shared pipeline definitions: reset fetch address, bubble encoding and the
// fetch-state enum used by the IF stage, hazard unit and ID stage.
package if_stage_hazard_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_stage_hazard_ifid.sv
// IF/ID pipeline register: flush (bubble, PC kept) beats load, otherwise hold.
module ifid_reg #(
  parameter logic [31:0] NOP_INSTR = if_stage_hazard_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_ifid,
  output logic [31:0] instr_ifid,
  output logic        valid_ifid
);

  // IF/ID state update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_ifid    <= 32'h0000_0000;
      instr_ifid <= NOP_INSTR;
      valid_ifid <= 1'b0;
    end else if (flush) begin
      instr_ifid <= NOP_INSTR;
      valid_ifid <= 1'b0;
    end else if (load) begin
      pc_ifid    <= pc_in;
      instr_ifid <= instr_in;
      valid_ifid <= 1'b1;
    end else begin
      valid_ifid <= valid_ifid;
    end
  end

endmodule

// File: rtl/if_stage_hazard.sv
// Instruction-fetch stage: PC, variable-latency imem handshake, stall hold
// buffer and branch-redirect drain of an in-flight fetch.
module if_stage_hazard #(
  parameter logic [31:0] RESET_PC  = if_stage_hazard_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = if_stage_hazard_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken_EX,
  input  logic [31:0] branch_target_EX,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] PC_IFID,
  output logic [31:0] Instruc_IFID,
  output logic        valid_IFID
);

  import if_stage_hazard_pkg::*;

  fetch_state_t state_r, state_nxt_s;
  logic [31:0]  pc_r, pc_nxt_s, pc_inc_s;
  logic [31:0]  drain_addr_r, drain_nxt_s;
  logic [31:0]  buf_r, buf_nxt_s;
  logic         load_s, flush_s;
  logic [31:0]  ifid_instr_s;

  assign pc_inc_s     = pc_r + 32'd4;
  assign imem_req     = (state_r == FETCH) || (state_r == DRAIN);
  assign imem_addr    = (state_r == DRAIN) ? drain_addr_r : pc_r;
  assign ifid_instr_s = (state_r == HOLD) ? buf_r : imem_rdata;

  // Next-state, PC and IF/ID control decode
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    drain_nxt_s = drain_addr_r;
    buf_nxt_s   = buf_r;
    load_s      = 1'b0;
    flush_s     = 1'b0;
    case (state_r)
      IDLE: begin
        state_nxt_s = FETCH;
        if (branch_taken_EX) begin
          pc_nxt_s = branch_target_EX;
          flush_s  = 1'b1;
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      FETCH: begin
        if (branch_taken_EX) begin
          flush_s  = 1'b1;
          pc_nxt_s = branch_target_EX;
          // An unanswered request must be drained at its original address
          if (imem_valid) begin
            state_nxt_s = FETCH;
          end else begin
            drain_nxt_s = pc_r;
            state_nxt_s = DRAIN;
          end
        end else if (imem_valid && !stall) begin
          load_s   = 1'b1;
          pc_nxt_s = pc_inc_s;
        end else if (imem_valid) begin
          buf_nxt_s   = imem_rdata;
          state_nxt_s = HOLD;
        end else if (!stall) begin
          flush_s = 1'b1;
        end else begin
          flush_s = 1'b0;
        end
      end
      HOLD: begin
        if (branch_taken_EX) begin
          flush_s     = 1'b1;
          pc_nxt_s    = branch_target_EX;
          buf_nxt_s   = 32'h0000_0000;
          state_nxt_s = FETCH;
        end else if (!stall) begin
          load_s      = 1'b1;
          pc_nxt_s    = pc_inc_s;
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      DRAIN: begin
        if (branch_taken_EX) begin
          pc_nxt_s = branch_target_EX;
          flush_s  = 1'b1;
        end else begin
          flush_s = !stall;
        end
        if (imem_valid) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Fetch-control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      pc_r         <= RESET_PC;
      drain_addr_r <= 32'h0000_0000;
      buf_r        <= 32'h0000_0000;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      drain_addr_r <= drain_nxt_s;
      buf_r        <= buf_nxt_s;
    end
  end

  ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .flush     (flush_s),
    .pc_in     (pc_r),
    .instr_in  (ifid_instr_s),
    .pc_ifid   (PC_IFID),
    .instr_ifid(Instruc_IFID),
    .valid_ifid(valid_IFID)
  );

endmodule

// File: tb/tb_if_stage_hazard.sv
// Bench for if_stage_hazard: directed scenarios followed by random traffic,
// all compared cycle by cycle against a behavioural fetch model.
module tb_if_stage_hazard;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken_EX = 1'b0;
  logic [31:0] branch_target_EX = 32'h0000_0000;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0000_0000;
  logic        imem_valid = 1'b0;
  logic [31:0] PC_IFID;
  logic [31:0] Instruc_IFID;
  logic        valid_IFID;

  int checks = 0;
  int errors = 0;

  // Model: what the fetch stage should be doing, kept as plain flags
  bit          m_started, m_holding, m_draining;
  logic [31:0] m_pc, m_drain_addr, m_hold_data;
  logic [31:0] m_ifid_pc, m_ifid_instr;
  bit          m_ifid_v;

  if_stage_hazard dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .branch_taken_EX (branch_taken_EX),
    .branch_target_EX(branch_target_EX),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_valid      (imem_valid),
    .PC_IFID         (PC_IFID),
    .Instruc_IFID    (Instruc_IFID),
    .valid_IFID      (valid_IFID)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0; m_holding = 1'b0; m_draining = 1'b0;
    m_pc = RST_PC; m_drain_addr = 32'h0; m_hold_data = 32'h0;
    m_ifid_pc = 32'h0; m_ifid_instr = NOP; m_ifid_v = 1'b0;
  endtask

  task automatic bubble();
    m_ifid_instr = NOP;
    m_ifid_v = 1'b0;
  endtask

  task automatic deliver(input logic [31:0] instr);
    m_ifid_pc = m_pc;
    m_ifid_instr = instr;
    m_ifid_v = 1'b1;
    m_pc = m_pc + 32'd4;
  endtask

  // One clock edge of the fetch stage as seen from outside
  task automatic model_edge(input bit s, input bit b, input logic [31:0] t,
                            input bit v, input logic [31:0] d);
    if (!m_started) begin
      m_started = 1'b1;
      if (b) begin m_pc = t; bubble(); end
    end else if (m_holding) begin
      if (b) begin bubble(); m_pc = t; m_holding = 1'b0; end
      else if (!s) begin deliver(m_hold_data); m_holding = 1'b0; end
    end else if (m_draining) begin
      if (b) begin m_pc = t; bubble(); end
      else if (!s) bubble();
      if (v) m_draining = 1'b0;
    end else begin
      if (b) begin
        bubble();
        if (!v) begin m_draining = 1'b1; m_drain_addr = m_pc; end
        m_pc = t;
      end else if (v && !s) deliver(d);
      else if (v) begin m_hold_data = d; m_holding = 1'b1; end
      else if (!s) bubble();
    end
  endtask

  // Called at a falling edge: compare, drive inputs, advance model, wait one cycle
  task automatic step(input bit s, input bit b, input logic [31:0] t, input bit v,
                      input bit own_data, input logic [31:0] d);
    bit          exp_req;
    logic [31:0] exp_addr, rd;
    exp_req  = m_started && !m_holding;
    exp_addr = m_draining ? m_drain_addr : m_pc;
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    chk("imem_addr", imem_addr, exp_addr);
    chk("PC_IFID", PC_IFID, m_ifid_pc);
    chk("Instruc_IFID", Instruc_IFID, m_ifid_instr);
    chk("valid_IFID", {31'd0, valid_IFID}, {31'd0, m_ifid_v});
    rd = own_data ? d : exp_addr + 32'h0000_0100;
    stall = s; branch_taken_EX = b; branch_target_EX = t;
    imem_valid = v && exp_req; imem_rdata = rd;
    model_edge(s, b, t, v && exp_req, rd);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    chk("reset_req", {31'd0, imem_req}, 32'd0);
    chk("reset_addr", imem_addr, RST_PC);
    rst_n = 1'b1;

    // zero-wait stream 0,4,8 then a 3-cycle stall on the response at 8
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("first_instr", Instruc_IFID, 32'h0000_0104);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("hold_release_pc", PC_IFID, 32'h0000_0008);
    chk("hold_release_instr", Instruc_IFID, 32'hDEAD_BEEF);
    chk("hold_release_addr", imem_addr, 32'h0000_000C);

    // redirect to 0x10, then branch to 0x40 while 0x10 is still outstanding
    step(1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0);
    chk("drain_addr", imem_addr, 32'h0000_0010);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("after_drain_addr", imem_addr, 32'h0000_0040);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // branch + stall together at 0x20
    step(1'b0, 1'b1, 32'h0000_0020, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 32'h0);
    chk("br_stall_req", {31'd0, imem_req}, 32'd1);
    chk("br_stall_addr", imem_addr, 32'h0000_0080);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // PC wrap at the top of the address space
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // asynchronous reset while draining
    step(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_addr", imem_addr, RST_PC);
    chk("async_rst_pc", PC_IFID, 32'h0);
    chk("async_rst_instr", Instruc_IFID, NOP);
    chk("async_rst_valid", {31'd0, valid_IFID}, 32'd0);
    model_reset();
    stall = 1'b0; branch_taken_EX = 1'b0; imem_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) == 0, ($urandom % 10) == 0, $urandom & 32'hFFFF_FFFC,
           ($urandom % 2) == 0, 1'b1, $urandom);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage_hazard.md
Name: if_stage_hazard

Overview:
- Instruction-fetch stage of the hazard-aware 5-stage RISC-V pipeline; the writer of the IF/ID pipeline register consumed by the ID stage (Instruc_IFID, PC_IFID).
- Owns the PC, drives a variable-latency instruction-memory request/valid port, and honours the hazard unit's stall.
- Honours EX-stage branch redirect: flushes IF/ID to a NOP bubble and drains any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) loaded on flush/bubble

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  hazard unit: hold PC and IF/ID (load-use)
branch_taken_EX  input  1  redirect request from EX
branch_target_EX  input  32  redirect address
imem_req  output  1  fetch request, held until imem_valid
imem_addr  output  32  fetch address, stable while imem_req && !imem_valid
imem_rdata  input  32  instruction, qualified by imem_valid
imem_valid  input  1  response for current imem_addr; may be the same cycle as imem_req
PC_IFID  output  32  PC of the instruction in IF/ID
Instruc_IFID  output  32  instruction in IF/ID
valid_IFID  output  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset values: state IDLE, pc_reg=RESET_PC, PC_IFID=0, Instruc_IFID=NOP_INSTR, valid_IFID=0, buf=0, drain_addr=0.
- Reset outputs: imem_req=0; imem_addr=RESET_PC.
- Reset asserted mid-fetch abandons the outstanding request; memory must tolerate the dropped request.
- Registered: pc_reg, drain_addr, hold buffer buf, state, IF/ID.
- Combinational decode of state:
  - imem_req = FETCH or DRAIN.
  - imem_addr = drain_addr in DRAIN, else pc_reg.
- PC increment is pc_reg+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- IDLE: req=0. Next state FETCH. branch_taken_EX still loads pc_reg.
- FETCH, in priority order:
  - branch_taken_EX: IF/ID <= bubble (PC_IFID unchanged, NOP, valid 0); pc_reg <= target. If imem_valid, the response is discarded and state stays FETCH. Otherwise drain_addr <= pc_reg and state -> DRAIN.
  - imem_valid && !stall: IF/ID <= {pc_reg, imem_rdata, 1}; pc_reg += 4. Zero-wait memory gives 1 instr/cycle; fetch-to-IF/ID latency is 1 edge after valid.
  - imem_valid && stall: buf <= imem_rdata; IF/ID held; state -> HOLD.
  - !imem_valid && stall: IF/ID held, pc_reg held.
  - !imem_valid && !stall: IF/ID <= bubble.
- HOLD: req=0.
  - branch_taken_EX: flush IF/ID; pc_reg <= target; buf discarded; state -> FETCH.
  - !stall: IF/ID <= {pc_reg, buf, 1}; pc_reg += 4; state -> FETCH.
  - stall: everything held.
- DRAIN: req=1 at drain_addr.
  - imem_valid: response discarded; state -> FETCH. IF/ID bubble unless stall.
  - Further branch_taken_EX in DRAIN: pc_reg <= new target; stay DRAIN (latest target wins).
- Simultaneous branch_taken_EX and stall: branch wins; the flush overrides the hold.
- Protocol: imem_addr never changes while imem_req=1 and imem_valid=0.

Decomposition:
- Shared pipeline package holds NOP_INSTR, RESET_PC and the fetch-state enum (IDLE, FETCH, HOLD, DRAIN), shared with the hazard unit and ID stage.
- One natural sub-module: ifid_reg (IF/ID register with load/hold/flush controls).
- The FSM and PC logic stay in the parent.

Test Plan:
- Reset then zero-wait memory returning rdata=addr+0x100: IF/ID shows PC 0,4,8 with instr 0x100,0x104,0x108 on consecutive edges; valid_IFID=1 from the 2nd edge after reset release.
- Stall held 3 cycles with valid response 0xDEADBEEF at PC 8: enters HOLD, imem_req=0, IF/ID frozen. On release, IF/ID={8,0xDEADBEEF,1}, next fetch addr 0xC.
- Branch (target 0x40) while memory has 2-cycle latency on PC 0x10: IF/ID=NOP/valid 0; imem_addr stays 0x10 until valid. That response is discarded; next req addr 0x40.
- Branch and stall same cycle at PC 0x20 (target 0x80): flush occurs, next fetch 0x80, no HOLD entry.
- pc_reg forced to 0xFFFF_FFFC (via branch): after one accepted fetch, next imem_addr=0x0000_0000.
- rst_n asserted mid-DRAIN: all outputs return to reset values asynchronously; after release, the first request is to RESET_PC one cycle later.
